hwpe_buffer_packer: RTL and testbench

Width-converting stage directly upstream of `hwpe_buffer`. It accepts narrow beats on a valid/ready stream, packs them LSB-first into one BUFFER_WIDTH-bit word, and presents the word on a wide valid/ready port. That port drives `hwpe_buffer`'s `data_in`. Short (partial) words are closed early by a `last` flag and zero-padded.

---
 rtl/hwpe_buffer_pkg.sv | 28 ++
 rtl/hwpe_buffer_packer_if.sv | 37 +++
 rtl/hwpe_buffer_packer.sv | 106 ++++++++++
 tb/tb_hwpe_buffer_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_buffer_pkg
// Description : Shared types and helpers for the hwpe_buffer packer stage:
//               FSM state encoding, beat-count helper and parameter checks.
// Revision    : 1.0 - initial release
// ============================================================================
package hwpe_buffer_pkg;

  // Packer FSM: collecting beats, or holding a finished word
  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_e;

  // Number of narrow beats that make up one wide word
  function automatic int nb_beats(input int buffer_width, input int data_width);
    return buffer_width / data_width;
  endfunction

  // Wide word must be an exact multiple of the beat, with at least two beats
  function automatic bit params_ok(input int buffer_width, input int data_width);
    return (data_width > 0) && (buffer_width % data_width == 0) &&
           (buffer_width / data_width >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hwpe_buffer_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_buffer_packer_if
// Description : Narrow input stream and wide output stream of the packer.
//               'slave' is the packer's view, 'master' the environment's.
// Revision    : 1.0 - initial release
// ============================================================================
interface hwpe_buffer_packer_if #(
  parameter int BUFFER_WIDTH = 1024,
  parameter int DATA_WIDTH   = 32
);
  import hwpe_buffer_pkg::*;

  localparam int NB_BEATS = nb_beats(BUFFER_WIDTH, DATA_WIDTH);
  localparam int NB_W     = $clog2(NB_BEATS + 1);

  logic [DATA_WIDTH-1:0]   in_data_i;
  logic                    in_valid_i;
  logic                    in_last_i;
  logic                    in_ready_o;
  logic [BUFFER_WIDTH-1:0] out_data_o;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [NB_W-1:0]         out_nb_beats_o;

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_nb_beats_o
  );

  modport master (
    output in_data_i, in_valid_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_nb_beats_o
  );

endinterface
`default_nettype wire

// File: rtl/hwpe_buffer_packer.sv
`default_nettype none
// ============================================================================
// Module      : hwpe_buffer_packer
// Description : Packs DATA_WIDTH beats LSB-first into one BUFFER_WIDTH word.
//               A 'last' beat closes a short word early; unused slices are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module hwpe_buffer_packer
  import hwpe_buffer_pkg::*;
#(
  parameter int BUFFER_WIDTH = 1024,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  hwpe_buffer_packer_if.slave  bus
);

  localparam int NB_BEATS = nb_beats(BUFFER_WIDTH, DATA_WIDTH);
  localparam int CNT_W    = $clog2(NB_BEATS);
  localparam int NB_W     = $clog2(NB_BEATS + 1);

  // Refuse to elaborate with a width pair that cannot be packed evenly
  if (!params_ok(BUFFER_WIDTH, DATA_WIDTH)) begin : g_param_check
    $error("hwpe_buffer_packer: BUFFER_WIDTH must be a multiple of DATA_WIDTH with >= 2 beats");
  end

  packer_state_e           r_state;
  packer_state_e           w_state_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [BUFFER_WIDTH-1:0] r_word;
  logic [NB_W-1:0]         r_nb_beats;

  logic w_in_hs;
  logic w_out_hs;
  logic w_close;

  assign w_in_hs  = (r_state == FILL) && bus.in_valid_i;
  assign w_out_hs = (r_state == FULL) && bus.out_ready_i;
  // The counter never wraps by itself: the final slot always closes the word
  assign w_close  = (r_cnt == CNT_W'(NB_BEATS - 1)) || bus.in_last_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides both handshakes
  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_in_hs && w_close) w_state_next = FULL;
        FULL:    if (bus.out_ready_i)    w_state_next = FILL;
        default: w_state_next = FILL;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register
  always_comb begin
    bus.in_ready_o  = (r_state == FILL);
    bus.out_valid_o = (r_state == FULL);
  end

  // Beat counter, word register and beat-count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_word     <= '0;
      r_nb_beats <= '0;
    end else if (clear_i) begin
      r_cnt      <= '0;
      r_word     <= '0;
      r_nb_beats <= '0;
    end else if (w_out_hs) begin
      // Zero the word so a later short word carries no stale slices
      r_word     <= '0;
      r_nb_beats <= '0;
    end else if (w_in_hs) begin
      for (int b = 0; b < NB_BEATS; b++) begin
        if (r_cnt == CNT_W'(b)) begin
          r_word[b*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data_i;
        end
      end
      if (w_close) begin
        r_cnt      <= '0;
        r_nb_beats <= NB_W'(r_cnt) + NB_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_data_o     = r_word;
  assign bus.out_nb_beats_o = r_nb_beats;

endmodule
`default_nettype wire

// File: tb/tb_hwpe_buffer_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hwpe_buffer_packer
// Description : Directed and throttled-random checks of hwpe_buffer_packer
//               with a 128-bit word built from four 32-bit beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hwpe_buffer_packer;

  localparam int BW = 128;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk_i   = 1'b0;
  logic rst_i   = 1'b0;
  logic clear_i = 1'b0;

  always #5 clk_i = ~clk_i;

  hwpe_buffer_packer_if #(.BUFFER_WIDTH(BW), .DATA_WIDTH(DW)) bus ();

  hwpe_buffer_packer #(.BUFFER_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one beat and hold it until accepted
  task automatic push(input logic [DW-1:0] d, input logic last);
    bit acc = 1'b0;
    bus.in_data_i  = d;
    bus.in_last_i  = last;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bus.in_ready_o;
      tick();
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  // Wait for a word, check it, consume it and check the stage reopens
  task automatic pop(input string tag, input logic [BW-1:0] ed, input int en);
    bit seen = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (bus.out_valid_o) seen = 1'b1;
      else tick();
    end
    chk({tag, "_valid"}, BW'(seen), 1);
    chk({tag, "_data"}, bus.out_data_o, ed);
    chk({tag, "_nb"}, BW'(bus.out_nb_beats_o), BW'(en));
    tick();
    bus.out_ready_i = 1'b0;
    chk({tag, "_in_ready_after"}, BW'(bus.in_ready_o), 1);
  endtask

  logic [BW-1:0] exp_q[$];
  int            nb_q[$];
  logic [BW-1:0] mword;
  int            mcnt;
  int            n_closed;
  int            n_words;
  int            cycles;
  bit            hs_in;
  bit            hs_out;
  logic [BW-1:0] e_word;
  int            e_nb;

  initial begin
    bus.in_data_i   = '0;
    bus.in_valid_i  = 1'b0;
    bus.in_last_i   = 1'b0;
    bus.out_ready_i = 1'b0;

    // Reset values
    #1 rst_i = 1'b1;
    #1;
    chk("rst_in_ready", BW'(bus.in_ready_o), 1);
    chk("rst_out_valid", BW'(bus.out_valid_o), 0);
    chk("rst_out_data", bus.out_data_o, 0);
    chk("rst_nb", BW'(bus.out_nb_beats_o), 0);
    tick();
    tick();
    rst_i = 1'b0;

    // Full word; valid the cycle after the fourth beat
    push(32'h11111111, 1'b0);
    push(32'h22222222, 1'b0);
    push(32'h33333333, 1'b0);
    push(32'h44444444, 1'b0);
    chk("full_latency_valid", BW'(bus.out_valid_o), 1);
    chk("full_in_ready_low", BW'(bus.in_ready_o), 0);
    pop("full", 128'h44444444_33333333_22222222_11111111, 4);
    chk("full_word_cleared", bus.out_data_o, 0);

    // Partial word, then a full word with no stale slices
    push(32'h0000000A, 1'b0);
    push(32'h0000000B, 1'b1);
    pop("partial", 128'h00000000_00000000_0000000B_0000000A, 2);
    push(32'hA0000001, 1'b0);
    push(32'hA0000002, 1'b0);
    push(32'hA0000003, 1'b0);
    push(32'hA0000004, 1'b0);
    pop("after_partial", 128'hA0000004_A0000003_A0000002_A0000001, 4);

    // Backpressure: word held, beats refused
    push(32'hC0000001, 1'b0);
    push(32'hC0000002, 1'b0);
    push(32'hC0000003, 1'b0);
    push(32'hC0000004, 1'b0);
    bus.in_data_i  = 32'hDEADBEEF;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_in_ready", BW'(bus.in_ready_o), 0);
    chk("bp_data_stable", bus.out_data_o, 128'hC0000004_C0000003_C0000002_C0000001);
    chk("bp_nb_stable", BW'(bus.out_nb_beats_o), 4);
    bus.in_valid_i = 1'b0;
    pop("bp", 128'hC0000004_C0000003_C0000002_C0000001, 4);
    // Single-beat word also proves nothing was consumed while FULL
    push(32'hDEADBEEF, 1'b1);
    pop("one_beat", 128'hDEADBEEF, 1);

    // Last on the final beat is an ordinary full word
    push(32'h01010101, 1'b0);
    push(32'h02020202, 1'b0);
    push(32'h03030303, 1'b0);
    push(32'h04040404, 1'b1);
    pop("last_on_4", 128'h04040404_03030303_02020202_01010101, 4);

    // Clear mid-word drops the collected beats and the beat in that cycle
    push(32'hBAD00001, 1'b0);
    push(32'hBAD00002, 1'b0);
    bus.in_data_i  = 32'hBAD00003;
    bus.in_valid_i = 1'b1;
    clear_i        = 1'b1;
    tick();
    clear_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    push(32'hF0000001, 1'b0);
    push(32'hF0000002, 1'b0);
    push(32'hF0000003, 1'b0);
    push(32'hF0000004, 1'b0);
    pop("after_clear", 128'hF0000004_F0000003_F0000002_F0000001, 4);

    // Clear in FULL wins over a simultaneous output handshake
    push(32'h0000E001, 1'b0);
    push(32'h0000E002, 1'b1);
    bus.out_ready_i = 1'b1;
    clear_i         = 1'b1;
    tick();
    clear_i         = 1'b0;
    bus.out_ready_i = 1'b0;
    chk("clr_full_valid", BW'(bus.out_valid_o), 0);
    chk("clr_full_in_ready", BW'(bus.in_ready_o), 1);
    chk("clr_full_data", bus.out_data_o, 0);
    chk("clr_full_nb", BW'(bus.out_nb_beats_o), 0);

    // Asynchronous reset while FULL
    push(32'h0000D001, 1'b0);
    push(32'h0000D002, 1'b0);
    push(32'h0000D003, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", BW'(bus.out_valid_o), 0);
    chk("arst_data", bus.out_data_o, 0);
    chk("arst_nb", BW'(bus.out_nb_beats_o), 0);
    tick();
    rst_i = 1'b0;
    push(32'h12345678, 1'b1);
    pop("post_rst", 128'h12345678, 1);

    // Throttled random traffic against a scoreboard
    mword    = '0;
    mcnt     = 0;
    n_closed = 0;
    n_words  = 0;
    cycles   = 0;
    while (n_words < 1000 && cycles < 40000) begin
      if (!bus.in_valid_i && n_closed < 1000 && $urandom_range(0, 3) != 0) begin
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = $urandom;
        bus.in_last_i  = ($urandom_range(0, 3) == 0);
      end
      bus.out_ready_i = ($urandom_range(0, 2) != 0);
      hs_in  = bus.in_valid_i && bus.in_ready_o;
      hs_out = bus.out_valid_o && bus.out_ready_i;
      if (hs_out) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_word", 1, 0);
        end else begin
          e_word = exp_q.pop_front();
          e_nb   = nb_q.pop_front();
          chk("rnd_data", bus.out_data_o, e_word);
          chk("rnd_nb", BW'(bus.out_nb_beats_o), BW'(e_nb));
        end
        n_words++;
      end
      if (hs_in) begin
        mword[mcnt*DW +: DW] = bus.in_data_i;
        mcnt++;
        if (bus.in_last_i || mcnt == NB) begin
          exp_q.push_back(mword);
          nb_q.push_back(mcnt);
          mword = '0;
          mcnt  = 0;
          n_closed++;
        end
      end
      tick();
      if (hs_in) begin
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
      end
      cycles++;
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    chk("rnd_word_count", BW'(n_words), 1000);
    chk("rnd_queue_empty", BW'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
